// File: rtl/tx_resp_arbiter.sv
// Purpose : merges ALU results (split LSB-first into bytes) and RF read data onto one TX FIFO write port.
// Latency : first W_INC two cycles after the valid pulse; ALU bytes go out back-to-back.
// Backpr. : FIFO_FULL freezes state and byte; full holding buffers drop new pulses and set DROP_ERR.
// Optional: define FRAME_TAG_EN to prefix each frame with a tag byte (TAG_RD / TAG_ALU).
module tx_resp_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16
`ifdef FRAME_TAG_EN
  ,
  parameter logic [DATA_WIDTH-1:0] TAG_RD  = 8'hA1,
  parameter logic [DATA_WIDTH-1:0] TAG_ALU = 8'hA2
`endif
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     FIFO_FULL,
  input  logic                     DROP_CLR,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     W_INC,
  output logic                     ALU_RDY,
  output logic                     RD_RDY,
  output logic                     DROP_ERR
);

  localparam int ALU_BYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CW        = (ALU_BYTES > 1) ? $clog2(ALU_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SEND_TAG, SEND_RD, SEND_ALU} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     last_alu_q, last_alu_d;   // 1: ALU won the last tie
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]    rd_buf_q, rd_buf_d;
  logic                     alu_pend_q, alu_pend_d;
  logic [ALU_OUT_WIDTH-1:0] alu_buf_q, alu_buf_d;
  logic                     drop_err_q, drop_err_d;
`ifdef FRAME_TAG_EN
  logic                     gnt_alu_q, gnt_alu_d;     // requester owning the frame in progress
`endif

  logic          w_inc;
  logic          rd_free, alu_free, pick_alu;
  logic          rd_cap, alu_cap;
  logic [CW-1:0] cnt_nxt;

  assign w_inc   = (state_q != IDLE) && !FIFO_FULL;
  assign cnt_nxt = cnt_q + 1'b1;

  // Grant selection, byte sequencing and buffer release.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_alu_d = last_alu_q;
    tx_data_d  = tx_data_q;
    rd_free    = 1'b0;
    alu_free   = 1'b0;
    pick_alu   = 1'b0;
`ifdef FRAME_TAG_EN
    gnt_alu_d  = gnt_alu_q;
`endif
    case (state_q)
      IDLE: begin
        if (rd_pend_q || alu_pend_q) begin
          // Round-robin only matters on a tie; a lone requester leaves the pointer alone.
          pick_alu = alu_pend_q && (!rd_pend_q || !last_alu_q);
          if (rd_pend_q && alu_pend_q) last_alu_d = pick_alu;
          cnt_d = '0;
`ifdef FRAME_TAG_EN
          gnt_alu_d = pick_alu;
          state_d   = SEND_TAG;
          tx_data_d = pick_alu ? TAG_ALU : TAG_RD;
`else
          state_d   = pick_alu ? SEND_ALU : SEND_RD;
          tx_data_d = pick_alu ? alu_buf_q[DATA_WIDTH-1:0] : rd_buf_q;
`endif
        end
      end
`ifdef FRAME_TAG_EN
      SEND_TAG: begin
        if (w_inc) begin
          state_d   = gnt_alu_q ? SEND_ALU : SEND_RD;
          tx_data_d = gnt_alu_q ? alu_buf_q[DATA_WIDTH-1:0] : rd_buf_q;
        end
      end
`endif
      SEND_RD: begin
        if (w_inc) begin
          rd_free = 1'b1;
          state_d = IDLE;
        end
      end
      SEND_ALU: begin
        if (w_inc) begin
          if (cnt_q == CW'(ALU_BYTES - 1)) begin
            cnt_d    = '0;
            alu_free = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d     = cnt_nxt;
            tx_data_d = alu_buf_q[int'(cnt_nxt)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding-buffer capture; a buffer freeing this cycle can take new data.
  always_comb begin
    rd_cap     = RdData_Valid && (!rd_pend_q || rd_free);
    alu_cap    = OUT_Valid && (!alu_pend_q || alu_free);
    rd_pend_d  = rd_cap || (rd_pend_q && !rd_free);
    alu_pend_d = alu_cap || (alu_pend_q && !alu_free);
    rd_buf_d   = rd_cap ? RdData : rd_buf_q;
    alu_buf_d  = alu_cap ? ALU_OUT : alu_buf_q;
    // Set beats clear when both happen in the same cycle.
    drop_err_d = drop_err_q;
    if (DROP_CLR) drop_err_d = 1'b0;
    if ((RdData_Valid && !rd_cap) || (OUT_Valid && !alu_cap)) drop_err_d = 1'b1;
  end

  // State registers with synchronous reset; a burst in flight is abandoned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_alu_q <= 1'b1;
      tx_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_buf_q   <= '0;
      alu_pend_q <= 1'b0;
      alu_buf_q  <= '0;
      drop_err_q <= 1'b0;
`ifdef FRAME_TAG_EN
      gnt_alu_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_alu_q <= last_alu_d;
      tx_data_q  <= tx_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_buf_q   <= rd_buf_d;
      alu_pend_q <= alu_pend_d;
      alu_buf_q  <= alu_buf_d;
      drop_err_q <= drop_err_d;
`ifdef FRAME_TAG_EN
      gnt_alu_q  <= gnt_alu_d;
`endif
    end
  end

  assign TX_P_DATA = tx_data_q;
  assign W_INC     = w_inc;
  assign ALU_RDY   = !alu_pend_q;
  assign RD_RDY    = !rd_pend_q;
  assign DROP_ERR  = drop_err_q;

endmodule
